spi_xfer_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares one SPI master core among N requesters. It picks one requester, drives that requester's slave select, byte and clock divider into the master, and pulses the master's enable. It then tracks the master's busy signal and returns the received byte with a one-cycle done pulse. It sits between the client logic and the single SPI master instance, which owns sclk, mosi and miso.

---
 rtl/spi_xfer_arbiter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_arbiter.sv
// ---------------------------------------------------------------------------
// spi_xfer_arbiter
//
// Shares a single SPI master core among N_REQ requesters. A round-robin
// arbiter picks one pending requester while idle, presents that requester's
// byte and clock divider to the master, drops its slave select, pulses the
// master enable, follows the master's busy signal and finally returns the
// received byte with a one-cycle done pulse to the owner.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-low
//   req          per-requester transfer request (held until that done)
//   req_data     byte to send, requester i in bits [8i+7:8i]
//   cfg_clk_div  SPI clock divider, same packing as req_data
//   grant        one-hot owner of the current transaction (registered)
//   done         one-cycle pulse to the owner when the transaction ends
//   err          valid with done; 1 = aborted because busy never rose
//   rx_data      received byte, valid with done, held until the next done
//   ss_n         active-low slave selects, at most one low
//   spi_enable   one-cycle start pulse to the SPI master
//   spi_dataIn   byte presented to the SPI master
//   spi_clk_div  divider presented to the SPI master
//   spi_busy     SPI master busy
//   spi_dataOut  SPI master received byte
// ---------------------------------------------------------------------------
module spi_xfer_arbiter #(
  parameter int N_REQ     = 4,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [8*N_REQ-1:0] cfg_clk_div,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic               err,
  output logic [7:0]         rx_data,
  output logic [N_REQ-1:0]   ss_n,
  output logic               spi_enable,
  output logic [7:0]         spi_dataIn,
  output logic [7:0]         spi_clk_div,
  input  logic               spi_busy,
  input  logic [7:0]         spi_dataOut
);

  // -------------------------------------------------------------------------
  // Widths and constants
  // -------------------------------------------------------------------------
  localparam int IDX_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  // The counter must hold SETUP_CYC-1, HOLD_CYC-1 (both <= 14) and TIMEOUT-1.
  localparam int CNT_MAX = (TIMEOUT > 15) ? TIMEOUT : 15;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0]   N_REQ_EXT = (IDX_W + 1)'(N_REQ);

  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ - 1){1'b0}}, 1'b1};

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SETUP     = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [2:0] ST_XFER      = 3'd4;
  localparam logic [2:0] ST_HOLD      = 3'd5;
  localparam logic [2:0] ST_RELEASE   = 3'd6;

  // -------------------------------------------------------------------------
  // Internal state
  // -------------------------------------------------------------------------
  logic [2:0]       state_reg;
  logic [IDX_W-1:0] ptr_reg;   // first index searched by the next arbitration
  logic [IDX_W-1:0] win_reg;   // owner of the transaction in flight
  logic [CNT_W-1:0] cnt_reg;   // shared down-counter for setup/timeout/hold
  logic [7:0]       cap_reg;   // byte captured when busy falls

  // -------------------------------------------------------------------------
  // Unpack the per-requester byte lanes
  // -------------------------------------------------------------------------
  logic [7:0] data_arr [N_REQ];
  logic [7:0] div_arr  [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign data_arr[gi] = req_data[8*gi +: 8];
      assign div_arr[gi]  = cfg_clk_div[8*gi +: 8];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin search
  //
  // cand_idx[k] is the requester examined k-th, i.e. (ptr + k) mod N_REQ.
  // The lowest k with a pending request wins.
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_hit;

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum          = {1'b0, ptr_reg} + (IDX_W + 1)'(gi);
      assign cand_idx[gi] = (sum >= N_REQ_EXT) ? IDX_W'(sum - N_REQ_EXT)
                                               : sum[IDX_W-1:0];
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    // Scan from the far end so the nearest hit to ptr is the last written.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  logic [N_REQ-1:0] pick_onehot;
  logic [N_REQ-1:0] win_onehot;

  assign pick_onehot = ONE_HOT0 << pick_idx;
  assign win_onehot  = ONE_HOT0 << win_reg;

  // -------------------------------------------------------------------------
  // Transaction end detection
  //
  // Both ways into RELEASE are decoded here so the done/err/rx_data/ss_n
  // updates are made on the same edge that enters RELEASE, which keeps all
  // of them registered and aligned with the RELEASE cycle.
  // -------------------------------------------------------------------------
  logic abort_now;      // busy never rose within TIMEOUT cycles of enable
  logic hold_end;       // last HOLD cycle of a normal transfer
  logic enter_release;

  always_comb begin
    abort_now     = (state_reg == ST_WAIT_BUSY) && !spi_busy && (cnt_reg == '0);
    hold_end      = (state_reg == ST_HOLD) && (cnt_reg == '0);
    enter_release = abort_now || hold_end;
  end

  logic [IDX_W-1:0] ptr_next;
  assign ptr_next = (win_reg == LAST_IDX) ? '0 : win_reg + 1'b1;

  // -------------------------------------------------------------------------
  // Sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      win_reg     <= '0;
      cnt_reg     <= '0;
      cap_reg     <= 8'h00;
      grant       <= '0;
      done        <= '0;
      err         <= 1'b0;
      rx_data     <= 8'h00;
      ss_n        <= '1;
      spi_enable  <= 1'b0;
      spi_dataIn  <= 8'h00;
      spi_clk_div <= 8'h00;
    end else begin
      // Pulse outputs default low every cycle.
      done       <= '0;
      spi_enable <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          // The only place req, req_data and cfg_clk_div are looked at.
          if (pick_valid) begin
            win_reg     <= pick_idx;
            grant       <= pick_onehot;
            ss_n        <= ~pick_onehot;
            spi_dataIn  <= data_arr[pick_idx];
            spi_clk_div <= div_arr[pick_idx];
            cnt_reg     <= SETUP_LOAD;
            state_reg   <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (cnt_reg == '0) begin
            spi_enable <= 1'b1;     // high for the whole START cycle
            state_reg  <= ST_START;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        ST_START: begin
          cnt_reg   <= TIMEOUT_LOAD;
          state_reg <= ST_WAIT_BUSY;
        end

        ST_WAIT_BUSY: begin
          // busy wins over an expiring counter on the same cycle.
          if (spi_busy) begin
            state_reg <= ST_XFER;
          end else if (cnt_reg == '0) begin
            state_reg <= ST_RELEASE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        ST_XFER: begin
          // Once the master has started there is no timeout.
          if (!spi_busy) begin
            cap_reg   <= spi_dataOut;
            cnt_reg   <= HOLD_LOAD;
            state_reg <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_RELEASE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        ST_RELEASE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase

      // Outputs visible during the RELEASE cycle.
      if (enter_release) begin
        ss_n    <= '1;
        grant   <= '0;
        done    <= win_onehot;
        err     <= abort_now;
        rx_data <= abort_now ? 8'h00 : cap_reg;
        ptr_reg <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_xfer_arbiter
//
// Directed bench for spi_xfer_arbiter with N_REQ=4, SETUP_CYC=2, HOLD_CYC=2,
// TIMEOUT=16. A table of transactions (requests, lane data, master response
// and hand-computed expected owner/bytes/err) is applied in order; each
// transaction is checked cycle by cycle against the timing of the block.
// A reset-in-flight sequence is written out by hand between table runs.
// ---------------------------------------------------------------------------
module tb_spi_xfer_arbiter;

  localparam int N_REQ     = 4;
  localparam int SETUP_CYC = 2;
  localparam int HOLD_CYC  = 2;
  localparam int TIMEOUT   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [31:0] cfg_clk_div;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        err;
  logic [7:0]  rx_data;
  logic [3:0]  ss_n;
  logic        spi_enable;
  logic [7:0]  spi_dataIn;
  logic [7:0]  spi_clk_div;
  logic        spi_busy;
  logic [7:0]  spi_dataOut;

  spi_xfer_arbiter #(
    .N_REQ     (N_REQ),
    .SETUP_CYC (SETUP_CYC),
    .HOLD_CYC  (HOLD_CYC),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .cfg_clk_div (cfg_clk_div),
    .grant       (grant),
    .done        (done),
    .err         (err),
    .rx_data     (rx_data),
    .ss_n        (ss_n),
    .spi_enable  (spi_enable),
    .spi_dataIn  (spi_dataIn),
    .spi_clk_div (spi_clk_div),
    .spi_busy    (spi_busy),
    .spi_dataOut (spi_dataOut)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // One transaction: stimulus, master response and expected results.
  // delay < 0 means the master never raises busy (timeout case).
  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [31:0] div;
    int          delay;   // edges after the enable edge before busy rises
    int          blen;    // edges busy stays high
    logic [7:0]  rx;      // byte the master returns
    int          win;     // expected owner
    logic [7:0]  din;     // expected spi_dataIn
    logic [7:0]  dv;      // expected spi_clk_div
    logic        eerr;    // expected err
    logic [7:0]  erx;     // expected rx_data
    bit          churn;   // disturb req/req_data mid-transaction
  } vec_t;

  vec_t tbl [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [3:0] oh;
    int e, b, f, d_exp;
    oh = 4'b0001 << v.win;
    e  = SETUP_CYC;
    if (v.delay >= 0) begin
      b     = e + v.delay;
      f     = b + v.blen;
      d_exp = f + HOLD_CYC + 1;
    end else begin
      b     = -10;
      f     = -10;
      d_exp = e + TIMEOUT + 1;
    end
    req         = v.req;
    req_data    = v.data;
    cfg_clk_div = v.div;
    spi_busy    = 1'b0;
    spi_dataOut = ~v.rx;

    // Edge 0: idle sees the request, grant/ss_n/bytes appear.
    step();
    chk($sformatf("v%0d grant", idx), {28'd0, grant}, {28'd0, oh});
    chk($sformatf("v%0d ss_n", idx), {28'd0, ss_n}, {28'd0, ~oh});
    chk($sformatf("v%0d dataIn", idx), {24'd0, spi_dataIn}, {24'd0, v.din});
    chk($sformatf("v%0d clk_div", idx), {24'd0, spi_clk_div}, {24'd0, v.dv});
    chk($sformatf("v%0d enable@0", idx), {31'd0, spi_enable}, 32'd0);

    for (int n = 1; n <= d_exp; n++) begin
      step();
      // Master model and request churn, driven just after edge n.
      if (n == b) begin
        spi_busy    = 1'b1;
        spi_dataOut = ~v.rx;
      end
      if (n == f) begin
        spi_busy    = 1'b0;
        spi_dataOut = v.rx;
      end
      if (n == f + 1) spi_dataOut = ~v.rx;
      if (v.churn && n == 1) begin
        req         = 4'b0000;
        req_data    = 32'hFFFF_FFFF;
        cfg_clk_div = 32'hFFFF_FFFF;
      end
      if (v.churn && n == b + 1) req_data = 32'h0000_0000;

      chk($sformatf("v%0d enable@%0d", idx, n), {31'd0, spi_enable}, {31'd0, (n == e)});
      chk($sformatf("v%0d dataIn@%0d", idx, n), {24'd0, spi_dataIn}, {24'd0, v.din});
      if (n < d_exp) begin
        chk($sformatf("v%0d done@%0d", idx, n), {28'd0, done}, 32'd0);
        chk($sformatf("v%0d ss_n@%0d", idx, n), {28'd0, ss_n}, {28'd0, ~oh});
      end else begin
        chk($sformatf("v%0d done", idx), {28'd0, done}, {28'd0, oh});
        chk($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, v.eerr});
        chk($sformatf("v%0d rx_data", idx), {24'd0, rx_data}, {24'd0, v.erx});
        chk($sformatf("v%0d ss_n release", idx), {28'd0, ss_n}, 32'h0000_000F);
      end
    end

    // Cycle after RELEASE: idle, nothing selected, byte held.
    step();
    chk($sformatf("v%0d idle ss_n", idx), {28'd0, ss_n}, 32'h0000_000F);
    chk($sformatf("v%0d idle grant", idx), {28'd0, grant}, 32'd0);
    chk($sformatf("v%0d idle done", idx), {28'd0, done}, 32'd0);
    chk($sformatf("v%0d rx held", idx), {24'd0, rx_data}, {24'd0, v.erx});
    $display("vec %0d: req=%b owner=%0d err=%b rx=%h", idx, v.req, v.win, err, rx_data);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " grant"}, {28'd0, grant}, 32'd0);
    chk({tag, " done"}, {28'd0, done}, 32'd0);
    chk({tag, " err"}, {31'd0, err}, 32'd0);
    chk({tag, " rx_data"}, {24'd0, rx_data}, 32'd0);
    chk({tag, " ss_n"}, {28'd0, ss_n}, 32'h0000_000F);
    chk({tag, " enable"}, {31'd0, spi_enable}, 32'd0);
    chk({tag, " dataIn"}, {24'd0, spi_dataIn}, 32'd0);
    chk({tag, " clk_div"}, {24'd0, spi_clk_div}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          req      data          div           dly blen rx     win din    dv     err   erx    churn
    tbl[0]  = '{4'b1111, 32'h13121110, 32'h23222120,  1,  3, 8'h50, 0, 8'h10, 8'h20, 1'b0, 8'h50, 1'b0};
    tbl[1]  = '{4'b1111, 32'h13121110, 32'h23222120,  2,  5, 8'h51, 1, 8'h11, 8'h21, 1'b0, 8'h51, 1'b0};
    tbl[2]  = '{4'b1111, 32'h13121110, 32'h23222120,  1,  1, 8'h52, 2, 8'h12, 8'h22, 1'b0, 8'h52, 1'b0};
    tbl[3]  = '{4'b1111, 32'h13121110, 32'h23222120,  3,  4, 8'h53, 3, 8'h13, 8'h23, 1'b0, 8'h53, 1'b0};
    tbl[4]  = '{4'b1111, 32'h13121110, 32'h23222120,  1,  2, 8'h54, 0, 8'h10, 8'h20, 1'b0, 8'h54, 1'b0};
    tbl[5]  = '{4'b0010, 32'h0000A500, 32'h00000400,  1, 20, 8'h3C, 1, 8'hA5, 8'h04, 1'b0, 8'h3C, 1'b0};
    tbl[6]  = '{4'b1000, 32'hEE000000, 32'h09000000,  1,  2, 8'h77, 3, 8'hEE, 8'h09, 1'b0, 8'h77, 1'b0};
    tbl[7]  = '{4'b1001, 32'h44000033, 32'h08000007,  1,  2, 8'h81, 0, 8'h33, 8'h07, 1'b0, 8'h81, 1'b0};
    tbl[8]  = '{4'b1001, 32'h44000033, 32'h08000007,  1,  2, 8'h82, 3, 8'h44, 8'h08, 1'b0, 8'h82, 1'b0};
    tbl[9]  = '{4'b0100, 32'h00550000, 32'h00060000, -1,  0, 8'h99, 2, 8'h55, 8'h06, 1'b1, 8'h00, 1'b0};
    tbl[10] = '{4'b0100, 32'h00550000, 32'h00060000, 16,  2, 8'hC7, 2, 8'h55, 8'h06, 1'b0, 8'hC7, 1'b0};
    tbl[11] = '{4'b0110, 32'h00BBAA00, 32'h00020100,  1,  2, 8'h5A, 1, 8'hAA, 8'h01, 1'b0, 8'h5A, 1'b0};
    tbl[12] = '{4'b0110, 32'h00BBAA00, 32'h00020100,  2,  3, 8'h5B, 2, 8'hBB, 8'h02, 1'b0, 8'h5B, 1'b0};
    // Applied after the reset-in-flight sequence (pointer back at 0).
    tbl[13] = '{4'b0100, 32'h00D20000, 32'h000A0000,  1,  2, 8'hE1, 2, 8'hD2, 8'h0A, 1'b0, 8'hE1, 1'b0};
    tbl[14] = '{4'b0010, 32'h00006C00, 32'h00000300,  1,  4, 8'h2F, 1, 8'h6C, 8'h03, 1'b0, 8'h2F, 1'b1};

    reset       = 1'b0;
    req         = 4'b0000;
    req_data    = 32'h0;
    cfg_clk_div = 32'h0;
    spi_busy    = 1'b0;
    spi_dataOut = 8'h00;
    step();
    step();
    chk_reset_values("reset");
    reset = 1'b1;

    for (int i = 0; i <= 12; i++) run_vec(i, tbl[i]);

    // Reset while the master is busy: drop the transaction, no done pulse.
    req         = 4'b0001;
    req_data    = 32'h000000C1;
    cfg_clk_div = 32'h00000005;
    step();                                        // edge 0: owner 0 (ptr 3 wraps to 0)
    chk("rst grant", {28'd0, grant}, 32'h0000_0001);
    chk("rst ss_n", {28'd0, ss_n}, 32'h0000_000E);
    step();                                        // edge 1
    step();                                        // edge 2: START
    chk("rst enable", {31'd0, spi_enable}, 32'd1);
    step();                                        // edge 3
    spi_busy    = 1'b1;
    spi_dataOut = 8'h66;
    step();                                        // edge 4: XFER
    chk("rst done@4", {28'd0, done}, 32'd0);
    step();                                        // edge 5
    chk("rst done@5", {28'd0, done}, 32'd0);
    reset = 1'b0;
    step();                                        // edge 6: reset taken
    chk_reset_values("rst mid-xfer");
    $display("reset mid-xfer: grant=%b ss_n=%b done=%b", grant, ss_n, done);
    reset    = 1'b1;
    spi_busy = 1'b0;

    for (int i = 13; i <= 14; i++) run_vec(i, tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
